onehot_pulse_decoder: RTL and testbench

- Buffers a stream of 3-bit priority codes and expands each one into an 8-bit one-hot pulse of programmable length.
- Codes use the 8-to-3 priority encoder's format, plus a `none` flag for "no input set".
- Sits downstream of the encoder and regenerates one-hot select lines for the consumer side.
- Adds a small FIFO, valid/ready input backpressure and a pulse/gap sequencer.

---
 rtl/onehot_pulse_decoder.sv | 158 +++++++++++++++
 tb/tb_onehot_pulse_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_pulse_decoder.sv
// Buffers 3-bit priority codes (plus a "none" flag) in a small FIFO and replays each
// one as an 8-bit one-hot pulse of PULSE_LEN cycles followed by GAP_LEN idle cycles.
module onehot_pulse_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     in_none,
  output logic [7:0]               out_onehot,
  output logic                     out_active,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [3:0]    PULSE_M1 = 4'(PULSE_LEN - 1);
  localparam logic [3:0]    GAP_M1   = 4'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [7:0] decode(input logic none, input logic [2:0] code);
    decode = none ? 8'h00 : (8'h01 << code);
  endfunction

  logic [3:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  state_t        state_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_s;
  logic [7:0]    pattern_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    head_s;
  logic          has_data_s;

  // Full blocks writes even when a pop happens on the same edge.
  assign in_ready   = (count_r != FULL_C) && !rst;
  assign push_s     = in_valid && in_ready;
  assign head_s     = mem_r[rd_ptr_r];
  assign has_data_s = (count_r != ZERO_C);
  assign count      = count_r;

  // FIFO storage: entry written at the tail on every accepted transfer.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_none, in_code};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Pulse/gap sequencer: next state, counter, pattern and FIFO pop.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pattern_s = out_onehot;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (has_data_s) begin
          pop_s     = 1'b1;
          pattern_s = decode(head_s[3], head_s[2:0]);
          cnt_s     = PULSE_M1;
          state_s   = DRIVE;
        end else begin
          pattern_s = 8'h00;
          state_s   = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else if (GAP_LEN != 0) begin
          pattern_s = 8'h00;
          cnt_s     = GAP_M1;
          state_s   = GAP;
        end else if (has_data_s) begin
          pop_s     = 1'b1;
          pattern_s = decode(head_s[3], head_s[2:0]);
          cnt_s     = PULSE_M1;
          state_s   = DRIVE;
        end else begin
          pattern_s = 8'h00;
          state_s   = IDLE;
        end
      end
      GAP: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else if (has_data_s) begin
          pop_s     = 1'b1;
          pattern_s = decode(head_s[3], head_s[2:0]);
          cnt_s     = PULSE_M1;
          state_s   = DRIVE;
        end else begin
          pattern_s = 8'h00;
          state_s   = IDLE;
        end
      end
      default: begin
        pattern_s = 8'h00;
        cnt_s     = 4'd0;
        state_s   = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset truncates any pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      out_onehot <= 8'h00;
      out_active <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      out_onehot <= pattern_s;
      out_active <= (state_s == DRIVE);
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench: two decoders (GAP_LEN 1 and 0) fed by directed and random codes,
// checked cycle by cycle against a pulse-schedule reference model.
module tb_onehot_pulse_decoder;

  localparam int D = 4;

  typedef struct {
    logic [7:0] pat;
    int         start;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid   [2];
  logic [2:0] in_code    [2];
  logic       in_none    [2];
  logic       in_ready   [2];
  logic [7:0] out_onehot [2];
  logic       out_active [2];
  logic [2:0] count      [2];

  exp_t exp_q   [2][$];
  int   start_q [2][$];
  int   model_count [2];
  int   last_start  [2];
  bit   acc [2];
  int   cyc;
  int   tests;
  int   fails;

  onehot_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1), .DEPTH(D)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .in_none(in_none[0]), .out_onehot(out_onehot[0]),
    .out_active(out_active[0]), .count(count[0])
  );

  onehot_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(0), .DEPTH(D)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .in_none(in_none[1]), .out_onehot(out_onehot[1]),
    .out_active(out_active[1]), .count(count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(input int k);
    plen = 4;
  endfunction

  function automatic int glen(input int k);
    glen = (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      if (fails <= 40)
        $display("FAIL %s[dut%0d] cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Reference model: a code accepted at edge t pulses from edge max(t+1, prev_start+PULSE+GAP).
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
          bit   rdy;
          int   s;
          exp_t e;
          rdy = (model_count[k] != D);
          while (start_q[k].size() > 0 && start_q[k][0] == cyc) begin
            void'(start_q[k].pop_front());
            model_count[k] = model_count[k] - 1;
          end
          acc[k] = in_valid[k] && rdy;
          if (acc[k]) begin
            s = cyc + 1;
            if (last_start[k] + plen(k) + glen(k) > s) s = last_start[k] + plen(k) + glen(k);
            last_start[k] = s;
            e.pat = 8'h00;
            if (!in_none[k]) e.pat[in_code[k]] = 1'b1;
            e.start = s;
            start_q[k].push_back(s);
            exp_q[k].push_back(e);
            model_count[k] = model_count[k] + 1;
          end
        end
      end
    end
  end

  // Monitor: compares outputs, occupancy and ready against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          logic       e_act;
          logic [7:0] e_pat;
          e_act = 1'b0;
          e_pat = 8'h00;
          if (exp_q[k].size() > 0 && exp_q[k][0].start <= cyc) begin
            e_act = 1'b1;
            e_pat = exp_q[k][0].pat;
          end
          chk("out_active", k, 32'(out_active[k]), 32'(e_act));
          chk("out_onehot", k, 32'(out_onehot[k]), 32'(e_pat));
          chk("count", k, 32'(count[k]), 32'(model_count[k]));
          chk("in_ready", k, 32'(in_ready[k]), 32'(model_count[k] != D));
          if (e_act && cyc >= exp_q[k][0].start + plen(k) - 1) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      start_q[k].delete();
      model_count[k] = 0;
      last_start[k]  = -1000;
      acc[k]         = 1'b0;
      in_valid[k]    = 1'b0;
    end
  endtask

  task automatic reset_checks();
    for (int k = 0; k < 2; k++) begin
      chk("rst_onehot", k, 32'(out_onehot[k]), 32'h0);
      chk("rst_active", k, 32'(out_active[k]), 32'h0);
      chk("rst_count", k, 32'(count[k]), 32'h0);
      chk("rst_ready", k, 32'(in_ready[k]), 32'h0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rel_ready", k, 32'(in_ready[k]), 32'h1);
      chk("rel_onehot", k, 32'(out_onehot[k]), 32'h0);
    end
  endtask

  // Present one code to both decoders, holding each until it is accepted.
  task automatic send(input logic [2:0] c, input logic n);
    bit pend [2];
    int guard;
    guard = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b1;
      in_code[k]  = c;
      in_none[k]  = n;
      pend[k]     = 1'b1;
    end
    while ((pend[0] || pend[1]) && guard < 200) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pend[k] && acc[k]) begin
          pend[k]     = 1'b0;
          in_valid[k] = 1'b0;
        end
      end
      guard = guard + 1;
    end
    if (pend[0] || pend[1]) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL send_timeout: code %0d not accepted, required acceptance within 200 cycles", c);
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && g < 2000) begin
      @(negedge clk);
      g = g + 1;
    end
    if (exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL drain_timeout: %0d/%0d pulses outstanding, required 0", exp_q[0].size(), exp_q[1].size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!in_valid[k] || acc[k]) begin
          in_valid[k] = ($urandom_range(0, 9) < 2);
          in_code[k]  = 3'($urandom_range(0, 7));
          in_none[k]  = ($urandom_range(0, 5) == 0);
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int k = 0; k < 2; k++) begin
      in_code[k] = 3'd0;
      in_none[k] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    release_reset();

    send(3'd5, 1'b0);
    wait_drain();

    for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
    wait_drain();

    send(3'd3, 1'b0);
    send(3'd0, 1'b1);
    send(3'd7, 1'b0);
    wait_drain();

    random_phase(600);
    wait_drain();

    for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    reset_checks();
    release_reset();

    random_phase(200);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
